// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, quadrant encoding and quarter-wave table generator for the DDS sine block
package dds_pkg;

   localparam int PHASE_W_DEF = 16;
   localparam int ADDR_W_DEF  = 5;
   localparam int DATA_W_DEF  = 8;

   // Quadrant of the folded index; bit 0 selects mirrored addressing, bit 1 selects negation
   typedef enum logic [1:0] {
      Q_RISE     = 2'd0,
      Q_FALL     = 2'd1,
      Q_NEG_FALL = 2'd2,
      Q_NEG_RISE = 2'd3
   } quad_e;

   // Cosine leads sine by one quadrant
   localparam logic [1:0] COS_OFFSET_Q = 2'd1;

   localparam real HALF_PI = 1.57079632679489661923;

   // Taylor series sine, accurate far beyond table resolution on [0, pi/2]
   function automatic real sin_q(input real x);
      real t, s;
      t = x;
      s = x;
      for (int i = 1; i < 12; i++) begin
         t = -t * x * x / real'((2 * i) * (2 * i + 1));
         s = s + t;
      end
      return s;
   endfunction

   // Table entry k: midpoint-sampled quarter sine, rounded to nearest, never zero at seams
   function automatic int lut_entry(input int k, input int addr_w, input int data_w);
      real amp, v;
      amp = real'((1 << (data_w - 1)) - 1);
      v   = amp * sin_q(HALF_PI * (real'(k) + 0.5) / real'(1 << addr_w));
      return $rtoi(v + 0.5);
   endfunction

endpackage

// File: rtl/dds_sine_gen_lut.sv
// lut_quarter_sine: combinational quarter-wave magnitude ROM built at elaboration
module lut_quarter_sine
   import dds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-2:0] mag_o
);

   logic [DATA_W-2:0] rom [2**ADDR_W];

   for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
      localparam logic [DATA_W-2:0] V = (DATA_W-1)'(lut_entry(k, ADDR_W, DATA_W));
      assign rom[k] = V;
   end

   assign mag_o = rom[addr_i];

endmodule

// File: rtl/dds_sine_gen.sv
// dds_sine_gen: phase accumulator, quadrant folding and two-stage signed sine/cosine pipeline
module dds_sine_gen
   import dds_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [PHASE_W-1:0] phase_inc,
   input  logic               phase_load,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               cos_sel,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int IW = ADDR_W + 2;

   logic [PHASE_W-1:0]       acc_q, acc_d;
   logic [ADDR_W-1:0]        s1_addr_q;
   logic                     s1_neg_q, s1_valid_q, s1_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_valid_q;
   logic [IW-1:0]            p;
   quad_e                    q;
   logic [ADDR_W-1:0]        idx, addr;
   logic                     neg, adv;
   logic [DATA_W-2:0]        mag;
   logic signed [DATA_W-1:0] mag_s;

   assign adv = !out_valid_q || out_ready;

   // Fold the top phase bits into a quarter-table address plus sign
   always_comb begin
      p     = acc_q[PHASE_W-1 -: IW] + {cos_sel ? COS_OFFSET_Q : 2'b00, {ADDR_W{1'b0}}};
      q     = quad_e'(p[IW-1 -: 2]);
      idx   = p[ADDR_W-1:0];
      addr  = (q == Q_FALL || q == Q_NEG_RISE) ? ~idx : idx;
      neg   = q == Q_NEG_FALL || q == Q_NEG_RISE;
      mag_s = {1'b0, mag};
      acc_d = phase_load ? phase_in : (adv && en) ? acc_q + phase_inc : acc_q;
      s1_valid_d = en && !phase_load;
      out_data_d = s1_neg_q ? -mag_s : mag_s;
   end

   lut_quarter_sine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lut (
      .addr_i (s1_addr_q),
      .mag_o  (mag)
   );

   // Accumulator: load wins even while stalled, otherwise advance on issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   // Pipeline stages move together only when the output slot can advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_addr_q   <= '0;
         s1_neg_q    <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         s1_addr_q   <= addr;
         s1_neg_q    <= neg;
         s1_valid_q  <= s1_valid_d;
         out_data_q  <= out_data_d;
         out_valid_q <= s1_valid_q;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
// tb_dds_sine_gen: directed vector and sequence checks for dds_sine_gen
module tb_dds_sine_gen;

   localparam int PW = 16, AW = 5, DW = 8;

   logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, phase_load = 1'b0;
   logic          cos_sel = 1'b0, out_ready = 1'b0;
   logic [PW-1:0] phase_inc = '0, phase_in = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;

   int n_cmp = 0, n_err = 0;
   int got[$];
   int s_sin[160], s_cos[160];

   typedef struct {
      logic cos;
      int   n;
      int   exp;
   } vec_t;
   vec_t vecs[9];

   dds_sine_gen #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .phase_inc  (phase_inc),
      .phase_load (phase_load),
      .phase_in   (phase_in),
      .cos_sel    (cos_sel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   function automatic int model(input int p);
      real v;
      v = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p % 128) + 0.5) / 128.0);
      return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      phase_load = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic collect(input int n, input bit bp);
      int   guard;
      logic stall;
      int   held;
      guard = 0;
      stall = 1'b0;
      held = 0;
      got.delete();
      while (got.size() < n && guard < 4000) begin
         if (stall) begin
            check("stall_hold_data", int'($signed(out_data)), held);
            check("stall_hold_valid", int'(out_valid), 1);
         end
         out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (out_valid && out_ready) got.push_back(int'($signed(out_data)));
         stall = out_valid && !out_ready;
         held = int'($signed(out_data));
         step();
         guard++;
      end
      if (got.size() < n) check("collect_timeout", got.size(), n);
   endtask

   initial begin
      int exp_q[$];
      logic [PW-1:0] acc_ref;
      vecs[0] = '{1'b0, 0, 3};
      vecs[1] = '{1'b0, 31, 127};
      vecs[2] = '{1'b0, 32, 127};
      vecs[3] = '{1'b0, 64, -3};
      vecs[4] = '{1'b0, 96, -127};
      vecs[5] = '{1'b0, 1, 9};
      vecs[6] = '{1'b1, 0, 127};
      vecs[7] = '{1'b1, 32, -3};
      vecs[8] = '{1'b1, 96, 3};

      #2;
      check("reset_valid", int'(out_valid), 0);
      check("reset_data", int'(out_data), 0);

      // idle after reset with en low: nothing emerges
      do_reset();
      step();
      step();
      step();
      check("idle_no_valid", int'(out_valid), 0);

      // sine stream, then cosine stream
      phase_inc = 16'd512;
      do_reset();
      en = 1'b1;
      collect(160, 1'b0);
      for (int i = 0; i < 160; i++) s_sin[i] = got[i];
      cos_sel = 1'b1;
      do_reset();
      en = 1'b1;
      collect(160, 1'b0);
      for (int i = 0; i < 160; i++) s_cos[i] = got[i];
      cos_sel = 1'b0;

      foreach (vecs[i])
         check($sformatf("vec%0d", i), vecs[i].cos ? s_cos[vecs[i].n] : s_sin[vecs[i].n], vecs[i].exp);
      for (int i = 0; i < 128; i++) check($sformatf("sin_model%0d", i), s_sin[i], model(i));
      for (int i = 0; i < 64; i++) check($sformatf("antisym%0d", i), s_sin[i + 64], -s_sin[i]);
      for (int i = 0; i < 32; i++) check($sformatf("period%0d", i), s_sin[i + 128], s_sin[i]);
      for (int i = 0; i < 128; i++) check($sformatf("cos_shift%0d", i), s_cos[i], s_sin[i + 32]);

      // random backpressure must not alter the accepted stream
      do_reset();
      en = 1'b1;
      collect(160, 1'b1);
      for (int i = 0; i < 160; i++) check($sformatf("bp%0d", i), got[i], s_sin[i]);

      // drain, load half-turn phase, run
      en = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();
      check("drained", int'(out_valid), 0);
      phase_in = 16'h8000;
      phase_load = 1'b1;
      step();
      phase_load = 1'b0;
      en = 1'b1;
      collect(3, 1'b0);
      check("load_first", got[0], -3);
      check("load_second", got[1], model(65));
      check("load_third", got[2], model(66));

      // load while stalled: pending samples survive, then restart from phase 0
      do_reset();
      en = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      step();
      check("stall_pending_valid", int'(out_valid), 1);
      check("stall_pending_data", int'($signed(out_data)), 3);
      phase_in = '0;
      phase_load = 1'b1;
      step();
      phase_load = 1'b0;
      check("load_stall_data", int'($signed(out_data)), 3);
      collect(4, 1'b0);
      check("load_stall_0", got[0], 3);
      check("load_stall_1", got[1], 9);
      check("load_stall_2", got[2], 3);
      check("load_stall_3", got[3], 9);

      // asynchronous reset mid-stream
      step();
      step();
      check("pre_rst_valid", int'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_data", int'(out_data), 0);
      step();
      rst_n = 1'b1;
      collect(2, 1'b0);
      check("post_rst_first", got[0], 3);
      check("post_rst_second", got[1], 9);

      // wrap with phase_inc=0xFFFF and en toggling against a reference accumulator
      phase_inc = 16'hFFFF;
      do_reset();
      acc_ref = '0;
      got.delete();
      exp_q.delete();
      for (int i = 0; i < 60; i++) begin
         en = (i < 48) && (i % 7 < 4);
         out_ready = 1'b1;
         if (out_valid) got.push_back(int'($signed(out_data)));
         if (en) begin
            exp_q.push_back(model(int'(acc_ref[PW-1 -: AW+2])));
            acc_ref = acc_ref + phase_inc;
         end
         step();
      end
      check("wrap_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("wrap%0d", i), got[i], exp_q[i]);
      check("wrap_first", exp_q.size() > 0 ? got[0] : 0, 3);
      check("wrap_second", got.size() > 1 ? got[1] : 0, -3);

      // out_valid tail after en drops
      phase_inc = 16'd512;
      en = 1'b1;
      step();
      step();
      step();
      en = 1'b0;
      step();
      check("tail_valid_1", int'(out_valid), 1);
      step();
      check("tail_valid_2", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
